// File: rtl/rx_block_packer.sv
// Packs bytes from uart_rxd into a BYTES_PER_BLOCK-byte block with a valid/ready handshake.
// Optional idle timeout for partial blocks is enabled with `define RX_PACKER_TIMEOUT_EN.
`timescale 1ns/1ps
module rx_block_packer #(
  parameter int unsigned BYTES_PER_BLOCK = 16,
  parameter int unsigned TIMEOUT_CYCLES  = 1000000
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 rxd_done,
  input  logic [7:0]                           data_in,
  input  logic                                 block_ready,
  input  logic                                 overrun_clr,
  output logic [8*BYTES_PER_BLOCK-1:0]         block_out,
  output logic                                 block_valid,
  output logic [$clog2(BYTES_PER_BLOCK+1)-1:0] byte_count,
  output logic                                 overrun,
  output logic                                 timeout
);

  localparam int unsigned BlockW = 8 * BYTES_PER_BLOCK;
  localparam int unsigned CntW   = $clog2(BYTES_PER_BLOCK + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(BYTES_PER_BLOCK - 1);

  if (BYTES_PER_BLOCK < 2) begin : g_bpb_check
    $error("rx_block_packer: BYTES_PER_BLOCK must be at least 2");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_timeout_check
    $error("rx_block_packer: TIMEOUT_CYCLES must be at least 2");
  end

  typedef enum logic {StFill, StHold} state_e;

  state_e            state_q, state_d;
  logic [BlockW-1:0] block_q, block_d;
  logic              valid_q, valid_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              overrun_q, overrun_d;
  logic              rxd_q;
  logic              byte_evt;
  logic              handshake;
  logic              overrun_set;

`ifdef RX_PACKER_TIMEOUT_EN
  localparam int unsigned IdleW = $clog2(TIMEOUT_CYCLES);
  localparam logic [IdleW-1:0] IdleLast = IdleW'(TIMEOUT_CYCLES - 1);

  logic [IdleW-1:0] idle_q, idle_d;
  logic             timeout_q, timeout_d;
  logic             idle_expired;
`endif

  // rxd_done stays high for a whole baud tick; only its rising edge is a byte.
  assign byte_evt  = rxd_done & ~rxd_q;
  assign handshake = valid_q & block_ready;

  always_comb begin
    state_d     = state_q;
    block_d     = block_q;
    valid_d     = valid_q;
    cnt_d       = cnt_q;
    overrun_set = 1'b0;
`ifdef RX_PACKER_TIMEOUT_EN
    timeout_d    = 1'b0;
    idle_expired = (state_q == StFill) && (cnt_q != '0) && (idle_q == IdleLast);
`endif

    unique case (state_q)
      StFill: begin
        if (byte_evt) begin
          block_d = {block_q[BlockW-9:0], data_in};
          cnt_d   = cnt_q + CntW'(1);
          if (cnt_q == LastCnt) begin
            state_d = StHold;
            valid_d = 1'b1;
          end
`ifdef RX_PACKER_TIMEOUT_EN
        end else if (idle_expired) begin
          block_d   = '0;
          cnt_d     = '0;
          timeout_d = 1'b1;
`endif
        end
      end
      StHold: begin
        if (handshake) begin
          state_d = StFill;
          valid_d = 1'b0;
          // A byte arriving with the handshake starts the next block.
          if (byte_evt) begin
            block_d = {{(BlockW-8){1'b0}}, data_in};
            cnt_d   = CntW'(1);
          end else begin
            cnt_d   = '0;
          end
        end else if (byte_evt) begin
          overrun_set = 1'b1;
        end
      end
      default: state_d = StFill;
    endcase

    overrun_d = overrun_set | (overrun_q & ~overrun_clr);

`ifdef RX_PACKER_TIMEOUT_EN
    if (byte_evt || handshake || (state_q != StFill) || (cnt_q == '0) || idle_expired) begin
      idle_d = '0;
    end else begin
      idle_d = idle_q + IdleW'(1);
    end
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StFill;
      block_q   <= '0;
      valid_q   <= 1'b0;
      cnt_q     <= '0;
      overrun_q <= 1'b0;
      rxd_q     <= 1'b0;
`ifdef RX_PACKER_TIMEOUT_EN
      idle_q    <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      block_q   <= block_d;
      valid_q   <= valid_d;
      cnt_q     <= cnt_d;
      overrun_q <= overrun_d;
      rxd_q     <= rxd_done;
`ifdef RX_PACKER_TIMEOUT_EN
      idle_q    <= idle_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  assign block_out   = block_q;
  assign block_valid = valid_q;
  assign byte_count  = cnt_q;
  assign overrun     = overrun_q;
`ifdef RX_PACKER_TIMEOUT_EN
  assign timeout     = timeout_q;
`else
  assign timeout     = 1'b0;
`endif

endmodule

// File: tb/tb_rx_block_packer.sv
// Scoreboard bench for rx_block_packer: directed stimulus, block monitor on block_valid rise.
`timescale 1ns/1ps
module tb_rx_block_packer;

  localparam int unsigned Bpb  = 16;
  localparam int unsigned Tmo  = 100;
  localparam int unsigned W    = 8 * Bpb;
  localparam int unsigned CntW = $clog2(Bpb + 1);
`ifdef RX_PACKER_TIMEOUT_EN
  // Long holds would legitimately time out a partial block with Tmo=100.
  localparam int HoldCyc = 40;
`else
  localparam int HoldCyc = 652;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            rxd_done = 1'b0;
  logic [7:0]      data_in = 8'h00;
  logic            block_ready = 1'b0;
  logic            overrun_clr = 1'b0;
  logic [W-1:0]    block_out;
  logic            block_valid;
  logic [CntW-1:0] byte_count;
  logic            overrun;
  logic            timeout;

  rx_block_packer #(
    .BYTES_PER_BLOCK(Bpb),
    .TIMEOUT_CYCLES (Tmo)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rxd_done   (rxd_done),
    .data_in    (data_in),
    .block_ready(block_ready),
    .overrun_clr(overrun_clr),
    .block_out  (block_out),
    .block_valid(block_valid),
    .byte_count (byte_count),
    .overrun    (overrun),
    .timeout    (timeout)
  );

  always #5 clk = ~clk;

  int           checks   = 0;
  int           failures = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_blk;
  logic         valid_prev = 1'b0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every new block presented must match the oldest expected block.
  always @(negedge clk) begin
    if (rst && block_valid && !valid_prev) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL block_unexpected: got %0h expected no block", block_out);
      end else begin
        exp_blk = exp_q.pop_front();
        check("block_out", block_out, exp_blk);
        check("block_count", W'(byte_count), W'(Bpb));
      end
    end
    valid_prev = block_valid;
  end

  // Raise rxd_done for hi cycles; check capture on the first edge, then idle gap cycles.
  task automatic send_byte(input logic [7:0] b, input int hi, input int gap, input int exp_cnt);
    @(negedge clk);
    data_in  = b;
    rxd_done = 1'b1;
    @(negedge clk);
    check("count_after_edge", W'(byte_count), W'(exp_cnt));
    check("valid_after_edge", W'(block_valid), W'(exp_cnt == Bpb));
    repeat (hi - 1) @(negedge clk);
    rxd_done = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got no finish expected finish before 3 ms");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int hit;
    int base;

    // Reset values, then async reset in the middle of a fill
    repeat (3) @(negedge clk);
    check("rst_count", W'(byte_count), '0);
    check("rst_valid", W'(block_valid), '0);
    check("rst_block", block_out, '0);
    check("rst_overrun", W'(overrun), '0);
    check("rst_timeout", W'(timeout), '0);
    rst = 1'b1;
    for (int i = 0; i < 5; i++) send_byte(8'hA1 + 8'(i), 4, 2, i + 1);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("async_rst_count", W'(byte_count), '0);
    check("async_rst_valid", W'(block_valid), '0);
    check("async_rst_block", block_out, '0);
    @(negedge clk);
    rst = 1'b1;

    // Full block 0x00..0x0F
    exp_q.push_back(128'h000102030405060708090a0b0c0d0e0f);
    for (int i = 0; i < 16; i++) send_byte(8'(i), HoldCyc, 20, i + 1);
    check("full_valid", W'(block_valid), W'(1));
    check("full_count", W'(byte_count), W'(16));

    // Overrun while holding, then handshake, then clear
    send_byte(8'hAA, 10, 5, 16);
    check("overrun_set", W'(overrun), W'(1));
    check("overrun_block_kept", block_out, 128'h000102030405060708090a0b0c0d0e0f);
    @(negedge clk);
    block_ready = 1'b1;
    @(negedge clk);
    block_ready = 1'b0;
    check("hs_valid", W'(block_valid), '0);
    check("hs_count", W'(byte_count), '0);
    check("overrun_sticky", W'(overrun), W'(1));
    overrun_clr = 1'b1;
    @(negedge clk);
    overrun_clr = 1'b0;
    check("overrun_cleared", W'(overrun), '0);

    // Second block with block_ready ignored mid-fill, then handshake + byte together
    exp_q.push_back(128'h101112131415161718191a1b1c1d1e1f);
    for (int i = 0; i < 16; i++) begin
      send_byte(8'h10 + 8'(i), 3, 2, i + 1);
      if (i == 4) begin
        block_ready = 1'b1;
        repeat (3) @(negedge clk);
        block_ready = 1'b0;
        check("fill_ready_ignored_count", W'(byte_count), W'(5));
        check("fill_ready_ignored_valid", W'(block_valid), '0);
      end
    end
    @(negedge clk);
    block_ready = 1'b1;
    data_in     = 8'h55;
    rxd_done    = 1'b1;
    @(negedge clk);
    block_ready = 1'b0;
    check("hs_evt_valid", W'(block_valid), '0);
    check("hs_evt_count", W'(byte_count), W'(1));
    check("hs_evt_block", block_out, W'(8'h55));
    check("hs_evt_overrun", W'(overrun), '0);
    rxd_done = 1'b0;

    // Partial block idle behaviour
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    send_byte(8'h01, 3, 1, 1);
    send_byte(8'h02, 3, 1, 2);
    @(negedge clk);
    data_in  = 8'h03;
    rxd_done = 1'b1;
    @(negedge clk);
    check("partial_count", W'(byte_count), W'(3));
    rxd_done = 1'b0;
    hit = 0;
    for (int k = 1; k <= 200 && hit == 0; k++) begin
      @(negedge clk);
      if (timeout) hit = k;
    end
`ifdef RX_PACKER_TIMEOUT_EN
    check("timeout_cycle", W'(hit), W'(100));
    check("timeout_count", W'(byte_count), '0);
    check("timeout_block", block_out, '0);
    @(negedge clk);
    check("timeout_pulse_end", W'(timeout), '0);
    base = 0;
`else
    check("no_timeout", W'(hit), '0);
    check("held_count", W'(byte_count), W'(3));
    check("held_block", block_out, W'(24'h010203));
    base = 3;
`endif

    // One long rxd_done pulse captures exactly once
    @(negedge clk);
    data_in  = 8'h7E;
    rxd_done = 1'b1;
    @(negedge clk);
    check("long_pulse_count", W'(byte_count), W'(base + 1));
    check("long_pulse_byte", W'(block_out[7:0]), W'(8'h7E));
    repeat (1999) @(negedge clk);
`ifdef RX_PACKER_TIMEOUT_EN
    check("long_pulse_count_end", W'(byte_count), '0);
`else
    check("long_pulse_count_end", W'(byte_count), W'(base + 1));
`endif
    rxd_done = 1'b0;
    repeat (5) @(negedge clk);
`ifdef RX_PACKER_TIMEOUT_EN
    check("fall_no_capture", W'(byte_count), '0);
`else
    check("fall_no_capture", W'(byte_count), W'(base + 1));
`endif

    check("scoreboard_empty", W'(exp_q.size()), '0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
